// File: rtl/simt_warp_scheduler.sv
// Round-robin SIMT warp scheduler: tracks per-slot IDLE/READY/PENDING state with PC and
// active mask, and offers one eligible warp per cycle to the fetch stage.

package pkg_opengpu;
    localparam int unsigned WARP_ID_WIDTH = 2;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned WARP_SIZE     = 32;
endpackage

module simt_warp_scheduler
    import pkg_opengpu::*;
#(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     launch_valid,
    input  logic [WARP_ID_WIDTH-1:0] launch_warp_id,
    input  logic [DATA_WIDTH-1:0]    launch_pc,
    input  logic [WARP_SIZE-1:0]     launch_mask,
    input  logic [NUM_WARPS-1:0]     stall_mask,
    input  logic                     issue_ack,
    input  logic                     release_valid,
    input  logic [WARP_ID_WIDTH-1:0] release_warp_id,
    input  logic                     selective_flush,
    input  logic [WARP_ID_WIDTH-1:0] flush_warp_id,
    input  logic [DATA_WIDTH-1:0]    correct_pc,
    input  logic                     exit_valid,
    input  logic [WARP_ID_WIDTH-1:0] exit_warp_id,
    output logic                     warp_valid,
    output logic [WARP_ID_WIDTH-1:0] warp_id,
    output logic [DATA_WIDTH-1:0]    warp_pc,
    output logic [WARP_SIZE-1:0]     warp_mask,
    output logic [NUM_WARPS-1:0]     active_warps,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_PENDING = 2'd2
    } slot_state_e;

    slot_state_e                  state_q [NUM_WARPS];
    slot_state_e                  state_d [NUM_WARPS];
    logic [DATA_WIDTH-1:0]        pc_q    [NUM_WARPS];
    logic [DATA_WIDTH-1:0]        pc_d    [NUM_WARPS];
    logic [WARP_SIZE-1:0]         mask_q  [NUM_WARPS];
    logic [WARP_SIZE-1:0]         mask_d  [NUM_WARPS];
    logic [WARP_ID_WIDTH-1:0]     rr_ptr_q;
    logic [WARP_ID_WIDTH-1:0]     rr_ptr_d;

    logic                         sel_found;
    logic [WARP_ID_WIDTH-1:0]     sel_id;
    logic [WARP_ID_WIDTH-1:0]     cand;
    logic                         issue_fire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= ST_IDLE;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
            end
            rr_ptr_q <= WARP_ID_WIDTH'(NUM_WARPS - 1);
        end else begin
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                state_q[i] <= state_d[i];
                pc_q[i]    <= pc_d[i];
                mask_q[i]  <= mask_d[i];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Round-robin pick: scan from rr_ptr+1, wrapping back to rr_ptr itself last
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_WARPS; k++) begin
            cand = rr_ptr_q + WARP_ID_WIDTH'(k);
            if (!sel_found && state_q[cand] == ST_READY && !stall_mask[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // Offer and status outputs
    always_comb begin
        warp_valid = enable & sel_found;
        warp_id    = '0;
        warp_pc    = '0;
        warp_mask  = '0;
        if (warp_valid) begin
            warp_id   = sel_id;
            warp_pc   = pc_q[sel_id];
            warp_mask = mask_q[sel_id];
        end
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            active_warps[i] = (state_q[i] != ST_IDLE);
        end
        busy = |active_warps;
    end

    assign issue_fire = warp_valid & issue_ack;

    // Per-slot next state; event priority exit > flush > launch > release > issue
    always_comb begin
        rr_ptr_d = issue_fire ? sel_id : rr_ptr_q;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            mask_d[i]  = mask_q[i];
            if (exit_valid && exit_warp_id == WARP_ID_WIDTH'(i)) begin
                state_d[i] = ST_IDLE;
            end else if (selective_flush && flush_warp_id == WARP_ID_WIDTH'(i)
                         && state_q[i] != ST_IDLE) begin
                state_d[i] = ST_READY;
                pc_d[i]    = correct_pc;
            end else if (launch_valid && launch_warp_id == WARP_ID_WIDTH'(i)
                         && state_q[i] == ST_IDLE) begin
                state_d[i] = ST_READY;
                pc_d[i]    = launch_pc;
                mask_d[i]  = launch_mask;
            end else if (release_valid && release_warp_id == WARP_ID_WIDTH'(i)
                         && state_q[i] == ST_PENDING) begin
                state_d[i] = ST_READY;
            end else if (issue_fire && sel_id == WARP_ID_WIDTH'(i)) begin
                state_d[i] = ST_PENDING;
                pc_d[i]    = pc_q[i] + DATA_WIDTH'(PC_STEP);
            end
        end
    end

endmodule

// File: tb/tb_simt_warp_scheduler.sv
// Self-checking bench for simt_warp_scheduler: expected offers are queued as stimulus is
// driven and compared when the scheduler presents a valid warp.

module tb_simt_warp_scheduler;
    import pkg_opengpu::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     enable;
    logic                     launch_valid;
    logic [WARP_ID_WIDTH-1:0] launch_warp_id;
    logic [DATA_WIDTH-1:0]    launch_pc;
    logic [WARP_SIZE-1:0]     launch_mask;
    logic [3:0]               stall_mask;
    logic                     issue_ack;
    logic                     release_valid;
    logic [WARP_ID_WIDTH-1:0] release_warp_id;
    logic                     selective_flush;
    logic [WARP_ID_WIDTH-1:0] flush_warp_id;
    logic [DATA_WIDTH-1:0]    correct_pc;
    logic                     exit_valid;
    logic [WARP_ID_WIDTH-1:0] exit_warp_id;
    logic                     warp_valid;
    logic [WARP_ID_WIDTH-1:0] warp_id;
    logic [DATA_WIDTH-1:0]    warp_pc;
    logic [WARP_SIZE-1:0]     warp_mask;
    logic [3:0]               active_warps;
    logic                     busy;

    typedef struct {
        logic [WARP_ID_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0]    pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    simt_warp_scheduler #(.NUM_WARPS(4), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .launch_valid(launch_valid), .launch_warp_id(launch_warp_id),
        .launch_pc(launch_pc), .launch_mask(launch_mask),
        .stall_mask(stall_mask), .issue_ack(issue_ack),
        .release_valid(release_valid), .release_warp_id(release_warp_id),
        .selective_flush(selective_flush), .flush_warp_id(flush_warp_id),
        .correct_pc(correct_pc), .exit_valid(exit_valid), .exit_warp_id(exit_warp_id),
        .warp_valid(warp_valid), .warp_id(warp_id), .warp_pc(warp_pc),
        .warp_mask(warp_mask), .active_warps(active_warps), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        launch_valid = 1'b0; launch_warp_id = '0; launch_pc = '0; launch_mask = '0;
        stall_mask = '0; issue_ack = 1'b0;
        release_valid = 1'b0; release_warp_id = '0;
        selective_flush = 1'b0; flush_warp_id = '0; correct_pc = '0;
        exit_valid = 1'b0; exit_warp_id = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic launch(input logic [1:0] id, input logic [31:0] pc, input logic [31:0] mask);
        launch_valid = 1'b1; launch_warp_id = id; launch_pc = pc; launch_mask = mask;
        tick();
        launch_valid = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        enable = 1'b1;
        rst_n  = 1'b0;
        #3;
        n_total++; if (warp_valid !== 1'b0) $display("FAIL reset_valid got=%0d exp=0", warp_valid); else n_pass++;
        n_total++; if (warp_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", warp_id); else n_pass++;
        n_total++; if (warp_pc !== 32'd0) $display("FAIL reset_pc got=%h exp=0", warp_pc); else n_pass++;
        n_total++; if (warp_mask !== 32'd0) $display("FAIL reset_mask got=%h exp=0", warp_mask); else n_pass++;
        n_total++; if (active_warps !== 4'd0) $display("FAIL reset_active got=%b exp=0000", active_warps); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0d exp=0", busy); else n_pass++;
        launch_valid = 1'b1; launch_warp_id = 2'd0; launch_pc = 32'h10;
        tick();
        launch_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_total++; if (active_warps !== 4'd0) $display("FAIL reset_launch_blocked got=%b exp=0000", active_warps); else n_pass++;
    endtask

    task automatic test_launch_issue;
        do_reset();
        enable = 1'b1;
        launch_valid = 1'b1; launch_warp_id = 2'd0; launch_pc = 32'h100; launch_mask = 32'hFFFF_FFFF;
        #1;
        n_total++; if (warp_valid !== 1'b0) $display("FAIL launch_no_bypass got=%0d exp=0", warp_valid); else n_pass++;
        tick();
        launch_valid = 1'b0;
        n_total++; if (warp_valid !== 1'b1) $display("FAIL launch_valid got=%0d exp=1", warp_valid); else n_pass++;
        n_total++; if (warp_id !== 2'd0) $display("FAIL launch_id got=%0d exp=0", warp_id); else n_pass++;
        n_total++; if (warp_pc !== 32'h100) $display("FAIL launch_pc got=%h exp=100", warp_pc); else n_pass++;
        n_total++; if (warp_mask !== 32'hFFFF_FFFF) $display("FAIL launch_mask got=%h exp=ffffffff", warp_mask); else n_pass++;
        n_total++; if (active_warps !== 4'b0001 || busy !== 1'b1) $display("FAIL launch_active got=%b/%0d exp=0001/1", active_warps, busy); else n_pass++;
        issue_ack = 1'b1;
        tick();
        issue_ack = 1'b0;
        n_total++; if (warp_valid !== 1'b0) $display("FAIL pending_not_offered got=%0d exp=0", warp_valid); else n_pass++;
        n_total++; if (active_warps !== 4'b0001) $display("FAIL pending_active got=%b exp=0001", active_warps); else n_pass++;
        issue_ack = 1'b1;
        tick();
        issue_ack = 1'b0;
        release_valid = 1'b1; release_warp_id = 2'd0;
        tick();
        release_valid = 1'b0;
        n_total++; if (warp_valid !== 1'b1 || warp_pc !== 32'h104) $display("FAIL release_reoffer got=%0d/%h exp=1/104", warp_valid, warp_pc); else n_pass++;
    endtask

    task automatic test_round_robin;
        logic       have_last;
        logic [1:0] last_id;
        int         cyc;
        exp_t       e;
        do_reset();
        enable = 1'b0;
        launch(2'd0, 32'h00, 32'hFFFF_FFFF);
        launch(2'd1, 32'h40, 32'hFFFF_FFFF);
        launch(2'd2, 32'h80, 32'hFFFF_FFFF);
        launch(2'd3, 32'hC0, 32'hFFFF_FFFF);
        sb_q.push_back('{2'd0, 32'h00});
        sb_q.push_back('{2'd1, 32'h40});
        sb_q.push_back('{2'd2, 32'h80});
        sb_q.push_back('{2'd3, 32'hC0});
        sb_q.push_back('{2'd0, 32'h04});
        enable = 1'b1; have_last = 1'b0; last_id = '0; cyc = 0;
        while (sb_q.size() > 0 && cyc < 20) begin
            release_valid = have_last; release_warp_id = last_id; issue_ack = 1'b0;
            #1;
            if (warp_valid) begin
                e = sb_q.pop_front();
                n_total++; if (warp_id !== e.id || warp_pc !== e.pc) $display("FAIL rr_order got=%0d/%h exp=%0d/%h", warp_id, warp_pc, e.id, e.pc); else n_pass++;
                issue_ack = 1'b1; have_last = 1'b1; last_id = warp_id;
            end else begin
                have_last = 1'b0;
            end
            tick();
            cyc++;
        end
        clear_inputs();
        n_total++; if (sb_q.size() != 0) $display("FAIL rr_timeout got=%0d left exp=0", sb_q.size()); else n_pass++;
        sb_q.delete();
    endtask

    task automatic test_stall;
        exp_t e;
        do_reset();
        enable = 1'b0;
        launch(2'd1, 32'h10, 32'h0000_00FF);
        launch(2'd2, 32'h20, 32'h0000_FF00);
        enable = 1'b1;
        sb_q.push_back('{2'd2, 32'h20});
        sb_q.push_back('{2'd1, 32'h10});
        stall_mask = 4'b0010;
        #1;
        e = sb_q.pop_front();
        n_total++; if (warp_valid !== 1'b1 || warp_id !== e.id || warp_pc !== e.pc) $display("FAIL stall_skip got=%0d/%0d/%h exp=1/%0d/%h", warp_valid, warp_id, warp_pc, e.id, e.pc); else n_pass++;
        issue_ack = 1'b1;
        tick();
        issue_ack = 1'b0;
        stall_mask = 4'b0110;
        #1;
        n_total++; if (warp_valid !== 1'b0 || warp_id !== 2'd0) $display("FAIL stall_none got=%0d/%0d exp=0/0", warp_valid, warp_id); else n_pass++;
        stall_mask = 4'b0000;
        #1;
        e = sb_q.pop_front();
        n_total++; if (warp_valid !== 1'b1 || warp_id !== e.id || warp_pc !== e.pc) $display("FAIL stall_drop got=%0d/%0d/%h exp=1/%0d/%h", warp_valid, warp_id, warp_pc, e.id, e.pc); else n_pass++;
        n_total++; if (warp_mask !== 32'h0000_00FF) $display("FAIL stall_drop_mask got=%h exp=000000ff", warp_mask); else n_pass++;
        enable = 1'b0;
        #1;
        n_total++; if (warp_valid !== 1'b0 || warp_pc !== 32'd0) $display("FAIL enable_low got=%0d/%h exp=0/0", warp_valid, warp_pc); else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_flush;
        exp_t e;
        do_reset();
        enable = 1'b0;
        launch(2'd0, 32'h100, 32'hFFFF_FFFF);
        enable = 1'b1;
        issue_ack = 1'b1; tick(); issue_ack = 1'b0;
        release_valid = 1'b1; release_warp_id = 2'd0; tick(); release_valid = 1'b0;
        issue_ack = 1'b1; tick(); issue_ack = 1'b0;
        n_total++; if (warp_valid !== 1'b0) $display("FAIL flush_pending got=%0d exp=0", warp_valid); else n_pass++;
        selective_flush = 1'b1; flush_warp_id = 2'd0; correct_pc = 32'h200;
        release_valid = 1'b1; release_warp_id = 2'd0;
        sb_q.push_back('{2'd0, 32'h200});
        tick();
        clear_inputs();
        e = sb_q.pop_front();
        n_total++; if (warp_valid !== 1'b1 || warp_id !== e.id || warp_pc !== e.pc) $display("FAIL flush_redirect got=%0d/%0d/%h exp=1/%0d/%h", warp_valid, warp_id, warp_pc, e.id, e.pc); else n_pass++;
        selective_flush = 1'b1; flush_warp_id = 2'd2; correct_pc = 32'h500;
        tick();
        clear_inputs();
        n_total++; if (active_warps !== 4'b0001) $display("FAIL flush_idle_ignored got=%b exp=0001", active_warps); else n_pass++;
    endtask

    task automatic test_exit;
        exp_t e;
        do_reset();
        enable = 1'b0;
        launch(2'd3, 32'h3F0, 32'h0000_000F);
        exit_valid = 1'b1; exit_warp_id = 2'd3;
        selective_flush = 1'b1; flush_warp_id = 2'd3; correct_pc = 32'h250;
        tick();
        clear_inputs();
        enable = 1'b1;
        #1;
        n_total++; if (warp_valid !== 1'b0 || active_warps !== 4'd0) $display("FAIL exit_wins got=%0d/%b exp=0/0000", warp_valid, active_warps); else n_pass++;
        sb_q.push_back('{2'd3, 32'h300});
        launch(2'd3, 32'h300, 32'h0000_000F);
        e = sb_q.pop_front();
        n_total++; if (warp_valid !== 1'b1 || warp_id !== e.id || warp_pc !== e.pc) $display("FAIL exit_relaunch got=%0d/%0d/%h exp=1/%0d/%h", warp_valid, warp_id, warp_pc, e.id, e.pc); else n_pass++;
    endtask

    task automatic test_pc_wrap;
        do_reset();
        enable = 1'b1;
        launch(2'd2, 32'hFFFF_FFFC, 32'h1);
        issue_ack = 1'b1; tick(); issue_ack = 1'b0;
        release_valid = 1'b1; release_warp_id = 2'd2; tick(); release_valid = 1'b0;
        n_total++; if (warp_valid !== 1'b1 || warp_pc !== 32'd0) $display("FAIL pc_wrap got=%0d/%h exp=1/0", warp_valid, warp_pc); else n_pass++;
    endtask

    task automatic test_ignore_and_reset;
        do_reset();
        enable = 1'b0;
        launch(2'd1, 32'h40, 32'h0000_000F);
        launch(2'd1, 32'h999, 32'h0000_00FF);
        enable = 1'b1;
        #1;
        n_total++; if (warp_valid !== 1'b1 || warp_id !== 2'd1 || warp_pc !== 32'h40 || warp_mask !== 32'hF) $display("FAIL launch_ignored got=%0d/%0d/%h/%h exp=1/1/40/f", warp_valid, warp_id, warp_pc, warp_mask); else n_pass++;
        enable = 1'b0;
        launch(2'd0, 32'h0, 32'h1);
        enable = 1'b1;
        rst_n = 1'b0;
        #1;
        n_total++; if (warp_valid !== 1'b0 || active_warps !== 4'd0 || busy !== 1'b0) $display("FAIL async_reset got=%0d/%b/%0d exp=0/0000/0", warp_valid, active_warps, busy); else n_pass++;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_launch_issue();
        test_round_robin();
        test_stall();
        test_flush();
        test_exit();
        test_pc_wrap();
        test_ignore_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simt_warp_scheduler.md
SIMT_WARP_SCHEDULER -- requirements
Module: simt_warp_scheduler

Interface
REQ-001 SHALL take parameter NUM_WARPS, default 4: number of warp slots; SHALL equal 2**WARP_ID_WIDTH.
REQ-002 SHALL take parameter PC_STEP, default 4: PC increment per issued instruction, in bytes.
REQ-003 SHALL take WARP_ID_WIDTH, DATA_WIDTH and WARP_SIZE from pkg_opengpu.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  global scheduling enable; when low, warp_valid SHALL be 0.
REQ-007 launch_valid  in  1  start a warp this cycle.
REQ-008 launch_warp_id  in  WARP_ID_WIDTH  slot to start.
REQ-009 launch_pc  in  DATA_WIDTH  start PC.
REQ-010 launch_mask  in  WARP_SIZE  initial active-thread mask.
REQ-011 stall_mask  in  NUM_WARPS  per-warp hazard stall; bit i high means warp i is not eligible.
REQ-012 issue_ack  in  1  fetch stage accepted the offered warp.
REQ-013 release_valid / release_warp_id  in  1 / WARP_ID_WIDTH  issued instruction resolved; warp may issue again.
REQ-014 selective_flush / flush_warp_id / correct_pc  in  1 / WARP_ID_WIDTH / DATA_WIDTH  branch-mispredict redirect.
REQ-015 exit_valid / exit_warp_id  in  1 / WARP_ID_WIDTH  warp executed EXIT.
REQ-016 warp_valid  out  1  offered warp is valid.
REQ-017 warp_id  out  WARP_ID_WIDTH  offered warp slot.
REQ-018 warp_pc  out  DATA_WIDTH  offered PC.
REQ-019 warp_mask  out  WARP_SIZE  offered mask.
REQ-020 active_warps  out  NUM_WARPS  bit i set when warp i is not IDLE.
REQ-021 busy  out  1  OR-reduction of active_warps.

Function
REQ-022 Each slot SHALL hold the state IDLE, READY or PENDING, plus pc[DATA_WIDTH] and mask[WARP_SIZE].
REQ-023 Eligible(i) SHALL be: state==READY and !stall_mask[i].
REQ-024 Selection SHALL be round-robin.
  - Search starts at (rr_ptr+1) mod NUM_WARPS.
  - The first eligible slot is offered.
  - Selection is combinational: same-cycle response to stall_mask and state.
REQ-025 warp_valid SHALL equal enable AND (any slot eligible).
  - warp_id/pc/mask SHALL reflect the selected slot.
  - When warp_valid is 0, warp_id/pc/mask SHALL be 0.
REQ-026 On issue_ack while warp_valid=1, at the next edge:
  - selected slot pc <= pc + PC_STEP (wraps modulo 2**DATA_WIDTH);
  - slot state <= PENDING;
  - rr_ptr <= selected id.
REQ-027 issue_ack while warp_valid=0 SHALL be ignored.
REQ-028 The offer SHALL hold stable until acknowledged.
  - Exception: the offer may change when stall_mask, a flush, an exit or a higher-priority READY slot changes eligibility.
REQ-029 release_valid for a PENDING slot SHALL set it to READY.
  - release_valid for a slot in any other state SHALL be ignored.
REQ-030 selective_flush for a non-IDLE slot SHALL set pc <= correct_pc and state <= READY; mask SHALL be unchanged.
REQ-031 selective_flush for an IDLE slot SHALL be ignored.
REQ-032 exit_valid SHALL set the slot to IDLE; pc and mask SHALL be retained but unused.
REQ-033 launch_valid for an IDLE slot SHALL load pc <= launch_pc and mask <= launch_mask, and set state <= READY.
  - launch_valid for a non-IDLE slot SHALL be ignored.
REQ-034 Same-slot, same-cycle priority SHALL be, highest first: exit > selective_flush > launch > release > issue_ack.
  - A lower-priority event on the same slot SHALL be dropped.
  - Events on different slots SHALL all take effect.
REQ-035 A slot offered and acknowledged in cycle N SHALL NOT be offered again before a release or flush.
  - The earliest re-offer is the cycle after that release or flush edge.
REQ-036 A launch at edge N SHALL make the slot offerable in cycle N+1 (no bypass).
REQ-037 active_warps and busy SHALL be registered-state derived, with no input bypass.

Reset
REQ-038 On rst_n low, asynchronously:
  - all slots IDLE, pc=0, mask=0;
  - rr_ptr = NUM_WARPS-1, so warp 0 wins first;
  - warp_valid=0, warp_id=0, warp_pc=0, warp_mask=0, active_warps=0, busy=0.
REQ-039 Reset asserted mid-operation SHALL discard all PENDING/READY warps; no launch takes effect until rst_n is high.

Verification
REQ-040 Launch w0 pc=0x100 mask=0xFFFFFFFF, enable=1 -> next cycle warp_valid=1, id=0, pc=0x100; after ack -> w0 PENDING, pc=0x104, warp_valid=0.
REQ-041 Launch w0..w3 pc=0x0/0x40/0x80/0xC0; ack every cycle and release each the cycle after its ack -> ids issue in order 0,1,2,3,0, with w0 re-offered at pc=0x4.
REQ-042 w1 and w2 READY, stall_mask=0b0010 -> offer id=2; drop the stall -> next offer after ack of w2 is w1.
REQ-043 w0 PENDING at pc=0x108; selective_flush w0, correct_pc=0x200, with release w0 in the same cycle -> w0 READY, pc=0x200; next offer pc=0x200.
REQ-044 exit_valid and selective_flush for w3 in the same cycle -> w3 IDLE, never offered; launch w3 pc=0x300 next cycle -> offered pc=0x300.
REQ-045 Launch targeting a READY w1 -> ignored (pc unchanged); rst_n pulse while warps READY -> warp_valid=0, active_warps=0 immediately.
